// File: rtl/cordic_angle_feeder.sv
// ---------------------------------------------------------------------------
// cordic_angle_feeder
//
// Angle source for the pipelined CORDIC sin/cos core. A phase accumulator
// sweeps from phase_start in steps of phase_step and wraps in [-pi, pi).
// Each phase is folded into the CORDIC convergence range [-pi/2, pi/2]. The
// fold is flagged on cos_neg, and cos_neg is delayed by the core latency so
// the downstream sign-fix stage sees the flag with the matching result.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low
//   ce           clock enable shared with the CORDIC core
//   start        begin a sweep (sampled when ce=1 in IDLE)
//   abort        cancel the sweep; sampled every clock, independent of ce
//   phase_start  signed initial phase (PW bits, FXP_MUL scale)
//   phase_step   signed per-sample increment, |phase_step| <= pi
//   n_samples    number of angles to emit (0 = ignored)
//   angle_out    reduced angle to CORDIC angle_in (signed, W bits)
//   angle_valid  angle_out holds a sweep sample
//   cos_neg      quadrant flag aligned with angle_out
//   cos_neg_dly  cos_neg delayed PIPE_LATENCY ce-cycles
//   busy         sweep or drain in progress
//   done         one-clock pulse when the last result has left the core
// ---------------------------------------------------------------------------
module cordic_angle_feeder #(
  parameter int W            = 12,
  parameter int FXP_MUL      = 1024,
  parameter int PW           = 14,
  parameter int PIPE_LATENCY = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             start,
  input  logic             abort,
  input  logic [PW-1:0]    phase_start,
  input  logic [PW-1:0]    phase_step,
  input  logic [CNT_W-1:0] n_samples,
  output logic [W-1:0]     angle_out,
  output logic             angle_valid,
  output logic             cos_neg,
  output logic             cos_neg_dly,
  output logic             busy,
  output logic             done
);

  // round(x * FXP_MUL) with x given to 8 decimals; 64-bit to avoid overflow
  localparam longint PI_L      = (longint'(FXP_MUL) * 314159265 + 50000000) / 100000000;
  localparam longint HALF_PI_L = (longint'(FXP_MUL) * 157079633 + 50000000) / 100000000;
  localparam longint TWO_PI_L  = (longint'(FXP_MUL) * 628318531 + 50000000) / 100000000;

  localparam logic signed [PW:0] PI_FX      = (PW+1)'(PI_L);
  localparam logic signed [PW:0] HALF_PI_FX = (PW+1)'(HALF_PI_L);
  localparam logic signed [PW:0] TWO_PI_FX  = (PW+1)'(TWO_PI_L);

  localparam int DW = $clog2(PIPE_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_state_next;

  logic [PW-1:0]           r_phase;
  logic [PW-1:0]           r_step;
  logic [CNT_W-1:0]        r_remaining;
  logic [DW-1:0]           r_drain_cnt;
  logic [W-1:0]            r_angle;
  logic                    r_cos_neg;
  logic                    r_valid;
  logic                    r_done;
  logic [PIPE_LATENCY-1:0] r_dly;

  logic w_load, w_emit, w_drain_tick, w_done_set, w_kill;

  // Phase arithmetic is done one bit wider so phase+step cannot overflow.
  logic signed [PW:0] w_start_x, w_start_norm;
  logic signed [PW:0] w_phase_x, w_sum, w_sum_wrap;
  logic signed [PW:0] w_red;
  logic               w_red_neg;

  always_comb begin
    w_start_x = {phase_start[PW-1], phase_start};
    if (w_start_x >= PI_FX)
      w_start_norm = w_start_x - TWO_PI_FX;
    else if (w_start_x < -PI_FX)
      w_start_norm = w_start_x + TWO_PI_FX;
    else
      w_start_norm = w_start_x;

    w_phase_x = {r_phase[PW-1], r_phase};
    w_sum     = w_phase_x + {r_step[PW-1], r_step};
    if (w_sum >= PI_FX)
      w_sum_wrap = w_sum - TWO_PI_FX;
    else if (w_sum < -PI_FX)
      w_sum_wrap = w_sum + TWO_PI_FX;
    else
      w_sum_wrap = w_sum;

    // Fold outer quadrants onto the inner half-plane; cos changes sign there.
    if (w_phase_x > HALF_PI_FX) begin
      w_red     = PI_FX - w_phase_x;
      w_red_neg = 1'b1;
    end else if (w_phase_x < -HALF_PI_FX) begin
      w_red     = -PI_FX - w_phase_x;
      w_red_neg = 1'b1;
    end else begin
      w_red     = w_phase_x;
      w_red_neg = 1'b0;
    end
  end

  // Next-state and control strobes; abort overrides ce outside IDLE.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_emit       = 1'b0;
    w_drain_tick = 1'b0;
    w_done_set   = 1'b0;
    w_kill       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ce && start && !abort && (n_samples != '0)) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_kill       = 1'b1;
          w_state_next = S_IDLE;
        end else if (ce) begin
          w_emit = 1'b1;
          if (r_remaining == CNT_W'(1))
            w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_kill       = 1'b1;
          w_state_next = S_IDLE;
        end else if (ce) begin
          w_drain_tick = 1'b1;
          if (r_drain_cnt == DW'(1)) begin
            w_done_set   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_phase     <= '0;
      r_step      <= '0;
      r_remaining <= '0;
      r_drain_cnt <= '0;
      r_angle     <= '0;
      r_cos_neg   <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_set;
      if (w_load) begin
        r_phase     <= PW'(w_start_norm);
        r_step      <= phase_step;
        r_remaining <= n_samples;
      end
      if (w_emit) begin
        r_angle     <= W'(w_red);
        r_cos_neg   <= w_red_neg;
        r_valid     <= 1'b1;
        r_phase     <= PW'(w_sum_wrap);
        r_remaining <= r_remaining - CNT_W'(1);
        if (r_remaining == CNT_W'(1))
          r_drain_cnt <= DW'(PIPE_LATENCY);
      end
      if (w_drain_tick) begin
        r_valid     <= 1'b0;
        r_drain_cnt <= r_drain_cnt - DW'(1);
      end
      if (w_kill)
        r_valid <= 1'b0;
    end
  end

  // Quadrant-flag delay line: tap 0 takes cos_neg, last tap is the output.
  logic [PIPE_LATENCY-1:0] w_dly_in;

  generate
    if (PIPE_LATENCY == 1) begin : g_dly_one
      assign w_dly_in = r_cos_neg;
    end else begin : g_dly_many
      assign w_dly_in = {r_dly[PIPE_LATENCY-2:0], r_cos_neg};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset || w_kill)
      r_dly <= '0;
    else if (ce)
      r_dly <= w_dly_in;
  end

  assign angle_out   = r_angle;
  assign angle_valid = r_valid;
  assign cos_neg     = r_cos_neg;
  assign cos_neg_dly = r_dly[PIPE_LATENCY-1];
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_cordic_angle_feeder.sv
// ---------------------------------------------------------------------------
// tb_cordic_angle_feeder
//
// Self-checking bench. A behavioural model computes each sample's phase in
// closed form (start + k*step taken modulo 2*pi), folds it, and tracks the
// quadrant-flag history as a queue. A compare process checks every DUT
// output against the model on every falling edge. Directed sweeps add
// hand-computed literal expectations; a long randomized run follows.
// ---------------------------------------------------------------------------
module tb_cordic_angle_feeder;

  localparam int W     = 12;
  localparam int PW    = 14;
  localparam int CNT_W = 16;
  localparam int LAT   = 15;
  localparam int PI    = 3217;
  localparam int HPI   = 1608;
  localparam int TPI   = 6434;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             ce    = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PW-1:0]    phase_start = '0;
  logic [PW-1:0]    phase_step  = '0;
  logic [CNT_W-1:0] n_samples   = '0;
  logic [W-1:0]     angle_out;
  logic             angle_valid, cos_neg, cos_neg_dly, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  cordic_angle_feeder #(
    .W(W), .FXP_MUL(1024), .PW(PW), .PIPE_LATENCY(LAT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .ce(ce), .start(start), .abort(abort),
    .phase_start(phase_start), .phase_step(phase_step), .n_samples(n_samples),
    .angle_out(angle_out), .angle_valid(angle_valid), .cos_neg(cos_neg),
    .cos_neg_dly(cos_neg_dly), .busy(busy), .done(done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int wrap_pi(input int v);
    int r;
    r = (v + PI) % TPI;
    if (r < 0) r += TPI;
    return r - PI;
  endfunction

  function automatic int fold_angle(input int p);
    if (p > HPI) return PI - p;
    if (p < -HPI) return -PI - p;
    return p;
  endfunction

  function automatic int fold_neg(input int p);
    return ((p > HPI) || (p < -HPI)) ? 1 : 0;
  endfunction

  int m_mode = 0;  // 0 idle, 1 emitting, 2 draining
  int m_base, m_step, m_n, m_k, m_drain;
  int e_angle = 0, e_valid = 0, e_neg = 0, e_dly = 0, e_done = 0, e_busy = 0;
  int hist[$];
  bit model_ready = 1'b0;

  always @(posedge clock) begin
    e_done = 0;
    if (!reset) begin
      m_mode = 0; e_angle = 0; e_valid = 0; e_neg = 0; e_dly = 0;
      hist = {};
      for (int i = 0; i < LAT; i++) hist.push_back(0);
    end else if (m_mode != 0 && abort) begin
      m_mode = 0; e_valid = 0; e_dly = 0;
      hist = {};
      for (int i = 0; i < LAT; i++) hist.push_back(0);
    end else if (ce) begin
      hist.push_back(e_neg);
      void'(hist.pop_front());
      e_dly = hist[0];
      case (m_mode)
        0: if (start && !abort && n_samples != 0) begin
             m_base = wrap_pi(int'($signed(phase_start)));
             m_step = int'($signed(phase_step));
             m_n    = int'(n_samples);
             m_k    = 0;
             m_mode = 1;
           end
        1: begin
             int p;
             p = wrap_pi(m_base + m_k * m_step);
             e_angle = fold_angle(p);
             e_neg   = fold_neg(p);
             e_valid = 1;
             m_k++;
             if (m_k == m_n) begin m_mode = 2; m_drain = 0; end
           end
        default: begin
             e_valid = 0;
             m_drain++;
             if (m_drain == LAT) begin e_done = 1; m_mode = 0; end
           end
      endcase
    end
    e_busy = (m_mode != 0) ? 1 : 0;
    model_ready = 1'b1;
  end

  always @(negedge clock) begin
    if (model_ready) begin
      check("angle_out",   int'($signed(angle_out)), e_angle);
      check("angle_valid", int'(angle_valid), e_valid);
      check("cos_neg",     int'(cos_neg), e_neg);
      check("cos_neg_dly", int'(cos_neg_dly), e_dly);
      check("busy",        int'(busy), e_busy);
      check("done",        int'(done), e_done);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic start_sweep(input int ps, input int st, input int n);
    @(negedge clock);
    phase_start = PW'(ps);
    phase_step  = PW'(st);
    n_samples   = CNT_W'(n);
    start = 1'b1;
    ce    = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_lit(input string tag, input int ps, input int st, input int n,
                         input int a[8], input int g[8], input bit noisy);
    int c;
    start_sweep(ps, st, n);
    for (int i = 0; i < n; i++) begin
      if (noisy) begin
        start       = 1'b1;
        phase_start = PW'($urandom);
        n_samples   = CNT_W'(5);
      end
      @(negedge clock);
      check({tag, "_angle"}, int'($signed(angle_out)), a[i]);
      check({tag, "_neg"},   int'(cos_neg), g[i]);
      check({tag, "_valid"}, int'(angle_valid), 1);
    end
    start = 1'b0;
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (!done && c < 40);
    check({tag, "_done_latency"}, c, LAT);
    check({tag, "_dly_at_done"}, int'(cos_neg_dly), g[n-1]);
    $display("sweep %s: %0d samples, done after %0d clocks", tag, n, c);
  endtask

  initial begin
    int c;
    bit tog;
    int a_ramp[8] = '{0, 256, 512, 768, 1024, 1280, 1536, 1425};
    int g_ramp[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int a_q2[8]   = '{1500, 1461, 1205, 949, 0, 0, 0, 0};
    int g_q2[8]   = '{0, 1, 1, 1, 0, 0, 0, 0};
    int a_wr[8]   = '{117, -139, -395, 0, 0, 0, 0, 0};
    int g_wr[8]   = '{1, 1, 1, 0, 0, 0, 0, 0};

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      ce = 1'($urandom); start = 1'($urandom); abort = 1'($urandom);
      phase_start = PW'($urandom); phase_step = PW'($urandom);
      n_samples = CNT_W'($urandom);
    end
    @(negedge clock);
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(angle_valid), 0);
    check("rst_angle", int'(angle_out), 0);
    check("rst_done",  int'(done), 0);
    $display("reset: busy=%0d valid=%0d angle=%0d", busy, angle_valid, angle_out);
    reset = 1'b1; ce = 1'b1; start = 1'b0; abort = 1'b0;
    @(negedge clock);

    run_lit("ramp",  0,    256, 8, a_ramp, g_ramp, 1'b0);
    run_lit("quad2", 1500, 256, 4, a_q2,   g_q2,   1'b0);
    run_lit("wrap",  3100, 256, 3, a_wr,   g_wr,   1'b0);
    run_lit("busy_start", 1500, 256, 4, a_q2, g_q2, 1'b1);

    // ce toggled 1/0: each sample appears on a ce edge and holds through ce=0
    start_sweep(1500, 256, 4);
    for (int i = 0; i < 4; i++) begin
      ce = 1'b1;
      @(negedge clock);
      check("tog_angle", int'($signed(angle_out)), a_q2[i]);
      ce = 1'b0;
      @(negedge clock);
      check("tog_hold", int'($signed(angle_out)), a_q2[i]);
    end
    c = 0; tog = 1'b1;
    for (int k = 0; k < 80; k++) begin
      ce = tog;
      @(negedge clock);
      if (tog) c++;
      tog = !tog;
      if (done) break;
    end
    check("tog_done_ce_cycles", c, LAT);
    $display("sweep toggled-ce: done after %0d ce cycles", c);
    ce = 1'b1;

    // Abort after the third sample
    start_sweep(0, 100, 10);
    repeat (3) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_valid", int'(angle_valid), 0);
    check("abort_busy",  int'(busy), 0);
    check("abort_dly",   int'(cos_neg_dly), 0);
    c = 0;
    repeat (25) begin
      @(negedge clock);
      if (done) c++;
    end
    check("abort_no_done", c, 0);
    $display("sweep abort: busy=%0d done pulses=%0d", busy, c);

    // start with n_samples=0 is ignored
    start_sweep(500, 10, 0);
    @(negedge clock);
    check("n0_busy", int'(busy), 0);
    $display("sweep n=0: busy=%0d", busy);

    // Randomized run, model compared every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset       = ($urandom % 400) != 0;
      ce          = ($urandom % 4) != 0;
      start       = ($urandom % 6) == 0;
      abort       = ($urandom % 50) == 0;
      phase_start = PW'($urandom);
      phase_step  = PW'(int'($urandom_range(0, 2 * PI)) - PI);
      n_samples   = CNT_W'($urandom % 13);
    end
    @(negedge clock);
    reset = 1'b1; start = 1'b0; abort = 1'b0; ce = 1'b1;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
